adc_scan_sequencer: RTL and testbench
=====================================

// Module: adc_scan_sequencer
// PURPOSE
//   Scans a set of ADC channels once per sample period. Each one-cycle
//   sample_trigger pulse from the sample timer starts a scan of the enabled
//   channels. A conversion runs over a start/done handshake with the ADC
//   serial interface, and each result comes out tagged with its channel.
//   Sits between the sample timer and the ADC interface; results feed the
//   downstream filter/display logic.
// PARAMETERS
//   NUM_CHANNELS    4      number of ADC channels scanned (1..8)
//   DATA_WIDTH      12     ADC result width
//   CH_WIDTH        3      channel index width
//   TIMEOUT_CYCLES  1000   max cycles in WAIT before a conversion is abandoned
// PORTS
//   clk             in   1             system clock, all logic on posedge
//   reset           in   1             synchronous, active-high reset
//   sample_trigger  in   1             1-cycle pulse from sample timer
//   channel_enable  in   NUM_CHANNELS  per-channel scan enable
//   clear_flags     in   1             clears sticky overrun/timeout flags
//   adc_start       out  1             1-cycle conversion request to ADC
//   adc_channel     out  CH_WIDTH      channel for current conversion
//   adc_done        in   1             1-cycle pulse, adc_data valid
//   adc_data        in   DATA_WIDTH    conversion result
//   result_valid    out  1             1-cycle pulse, result_* valid
//   result_channel  out  CH_WIDTH      channel of result_data
//   result_data     out  DATA_WIDTH    captured result, held until next capture
//   frame_done      out  1             1-cycle pulse, scan complete
//   busy            out  1             high in any state other than IDLE
//   overrun         out  1             sticky: trigger arrived while busy
//   timeout_err     out  1             sticky: conversion timed out
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is synchronous and active-high.
// - Reset: state IDLE; all outputs 0; the timeout counter and the latched
//   mask are 0.
// - States: IDLE, START, WAIT, NEXT. All outputs are registered.
// - IDLE, trigger seen at edge k:
//   - latch channel_enable as the frame mask.
//   - mask nonzero: adc_channel = lowest enabled channel; START in cycle k+1.
//   - mask == 0: frame_done high in cycle k+1; stay in IDLE; no adc_start.
// - START: adc_start high for exactly this one cycle. Clear the timeout
//   counter, then go to WAIT.
// - WAIT: the counter increments each cycle.
//   - adc_done high: capture adc_data and adc_channel, go to NEXT with
//     capture flag set.
//   - otherwise, counter == TIMEOUT_CYCLES-1: set timeout_err, go to NEXT
//     with capture flag clear.
//   - adc_done wins over a timeout in the same cycle.
// - NEXT:
//   - result_valid high if the capture flag is set.
//   - if the latched mask has an enabled channel above adc_channel: load the
//     lowest such channel and go to START.
//   - else: frame_done high this cycle; go to IDLE.
// - Latency, trigger to first adc_start: 1 cycle. adc_done to result_valid:
//   1 cycle. result_valid to next adc_start: 1 cycle.
// - A channel_enable change mid-frame has no effect until the next frame.
// - sample_trigger outside IDLE is ignored and sets overrun. This covers a
//   trigger in the same cycle as frame_done.
// - clear_flags clears overrun and timeout_err. If a set event occurs in the
//   same cycle, the set wins.
// - adc_done outside WAIT is ignored.
// - Reset mid-scan: return to IDLE next edge. No partial result_valid or
//   frame_done is emitted.
// TESTING
// - All 4 enabled; done returns data 12'h100+ch, 20 cycles after each start
//   -> 4 starts on ch0..3 in order; results 12'h100..12'h103 tagged 0..3;
//   one frame_done, coincident with the ch3 result_valid.
// - Mask 4'b1010 -> conversions on ch1 and ch3 only; mask 4'b0000 ->
//   frame_done 1 cycle after trigger, no adc_start.
// - Trigger at edge k -> adc_start high in cycle k+1 only. done at edge j
//   -> result_valid high in cycle j+1; next adc_start in cycle j+2.
// - ch2 never returns done -> timeout_err set 1000 cycles after its start;
//   no result for ch2; ch3 converts normally.
//   - then clear_flags -> timeout_err 0.
// - Second trigger mid-scan -> overrun = 1; scan continues unchanged.
//   - then clear_flags and trigger in the same cycle while busy ->
//     overrun stays 1.
// - reset asserted while in WAIT -> IDLE next cycle; all outputs 0; the
//   next trigger starts a clean scan at ch0.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Scans the enabled ADC channels once per sample_trigger, running each
// conversion over a start/done handshake and emitting channel-tagged results.
module adc_scan_sequencer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int DATA_WIDTH     = 12,
    parameter int CH_WIDTH       = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_trigger,
    input  logic [NUM_CHANNELS-1:0] channel_enable,
    input  logic                    clear_flags,
    output logic                    adc_start,
    output logic [CH_WIDTH-1:0]     adc_channel,
    input  logic                    adc_done,
    input  logic [DATA_WIDTH-1:0]   adc_data,
    output logic                    result_valid,
    output logic [CH_WIDTH-1:0]     result_channel,
    output logic [DATA_WIDTH-1:0]   result_data,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, NEXT} state_t;

    state_t                  state, next_state;
    logic [NUM_CHANNELS-1:0] mask;
    logic [TW-1:0]           timer;
    logic [CH_WIDTH:0]       first_hit, next_hit;
    logic                    wait_exit;
    logic                    adc_start_d, result_valid_d, frame_done_d, busy_d;
    logic                    overrun_d, timeout_err_d;
    logic [CH_WIDTH-1:0]     adc_channel_d;

    // Returns {found, index} of the lowest set bit of m at or above lo.
    function automatic logic [CH_WIDTH:0] find_from(input logic [NUM_CHANNELS-1:0] m,
                                                    input int lo);
        logic [CH_WIDTH:0] r;
        r = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) begin
                r = {1'b1, CH_WIDTH'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        first_hit = find_from(channel_enable, 0);
        next_hit  = find_from(mask, int'(adc_channel) + 1);
        wait_exit = (state == WAIT) && (adc_done || timer == TIMER_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_trigger && first_hit[CH_WIDTH]) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (wait_exit) next_state = NEXT;
            NEXT:    next_state = next_hit[CH_WIDTH] ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered, so their next values are decoded one cycle ahead.
    always_comb begin
        adc_start_d    = (next_state == START);
        busy_d         = (next_state != IDLE);
        result_valid_d = (state == WAIT) && adc_done;
        frame_done_d   = ((state == IDLE) && sample_trigger && !first_hit[CH_WIDTH])
                       || (wait_exit && !next_hit[CH_WIDTH]);
        adc_channel_d  = adc_channel;
        if (state == IDLE && sample_trigger && first_hit[CH_WIDTH]) begin
            adc_channel_d = first_hit[CH_WIDTH-1:0];
        end else if (state == NEXT && next_hit[CH_WIDTH]) begin
            adc_channel_d = next_hit[CH_WIDTH-1:0];
        end
        overrun_d = overrun;
        if (sample_trigger && state != IDLE) begin
            overrun_d = 1'b1;
        end else if (clear_flags) begin
            overrun_d = 1'b0;
        end
        timeout_err_d = timeout_err;
        if (state == WAIT && !adc_done && timer == TIMER_MAX) begin
            timeout_err_d = 1'b1;
        end else if (clear_flags) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_start      <= 1'b0;
            adc_channel    <= '0;
            result_valid   <= 1'b0;
            result_channel <= '0;
            result_data    <= '0;
            frame_done     <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            timeout_err    <= 1'b0;
            mask           <= '0;
            timer          <= '0;
        end else begin
            adc_start    <= adc_start_d;
            adc_channel  <= adc_channel_d;
            result_valid <= result_valid_d;
            frame_done   <= frame_done_d;
            busy         <= busy_d;
            overrun      <= overrun_d;
            timeout_err  <= timeout_err_d;
            if (state == IDLE && sample_trigger) begin
                mask <= channel_enable;
            end
            if (state == START) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TW'(1);
            end
            if (state == WAIT && adc_done) begin
                result_data    <= adc_data;
                result_channel <= adc_channel;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized directed bench: an ADC responder and an event monitor run alongside
// one stimulus sequence; each frame is compared with a cycle-level frame model.
module tb_adc_scan_sequencer;

    localparam int NUM_CHANNELS   = 4;
    localparam int DATA_WIDTH     = 12;
    localparam int CH_WIDTH       = 3;
    localparam int TIMEOUT_CYCLES = 1000;

    logic                    clk;
    logic                    reset;
    logic                    sample_trigger;
    logic [NUM_CHANNELS-1:0] channel_enable;
    logic                    clear_flags;
    logic                    adc_start;
    logic [CH_WIDTH-1:0]     adc_channel;
    logic                    adc_done;
    logic [DATA_WIDTH-1:0]   adc_data;
    logic                    result_valid;
    logic [CH_WIDTH-1:0]     result_channel;
    logic [DATA_WIDTH-1:0]   result_data;
    logic                    frame_done;
    logic                    busy;
    logic                    overrun;
    logic                    timeout_err;

    logic                  resp_done, spur_done;
    logic [DATA_WIDTH-1:0] resp_data, spur_data;

    assign adc_done = resp_done | spur_done;
    assign adc_data = resp_done ? resp_data : spur_data;

    int              cyc;
    int              checks;
    int              passed;
    int              lat_tab[8];
    logic [11:0]     data_tab[8];
    bit              dead[8];
    int              trig_cyc;
    int              b_start, b_res, b_fd, b_to;

    int              log_start_ch[$], log_start_cyc[$];
    int              log_res_ch[$], log_res_cyc[$];
    logic [11:0]     log_res_data[$];
    int              log_fd_cyc[$], log_to_cyc[$];

    int              exp_start_ch[$], exp_start_cyc[$];
    int              exp_res_ch[$], exp_res_cyc[$];
    logic [11:0]     exp_res_data[$];
    int              exp_to_cyc[$];
    int              exp_fd_cyc;

    adc_scan_sequencer #(
        .NUM_CHANNELS  (NUM_CHANNELS),
        .DATA_WIDTH    (DATA_WIDTH),
        .CH_WIDTH      (CH_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_trigger(sample_trigger),
        .channel_enable(channel_enable),
        .clear_flags   (clear_flags),
        .adc_start     (adc_start),
        .adc_channel   (adc_channel),
        .adc_done      (adc_done),
        .adc_data      (adc_data),
        .result_valid  (result_valid),
        .result_channel(result_channel),
        .result_data   (result_data),
        .frame_done    (frame_done),
        .busy          (busy),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ADC model: answers each start lat_tab[ch] cycles later unless the channel is dead.
    initial begin
        int pend;
        int pch;
        pend      = 0;
        pch       = 0;
        resp_done = 1'b0;
        resp_data = '0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    resp_done = 1'b1;
                    resp_data = data_tab[pch];
                end
            end
            if (adc_start === 1'b1) begin
                pch = int'(adc_channel);
                if (!dead[pch]) pend = lat_tab[pch];
            end
        end
    end

    initial begin
        bit prev_to;
        prev_to = 1'b0;
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                log_start_ch.push_back(int'(adc_channel));
                log_start_cyc.push_back(cyc);
            end
            if (result_valid === 1'b1) begin
                log_res_ch.push_back(int'(result_channel));
                log_res_data.push_back(result_data);
                log_res_cyc.push_back(cyc);
            end
            if (frame_done === 1'b1) log_fd_cyc.push_back(cyc);
            if (timeout_err === 1'b1 && !prev_to) log_to_cyc.push_back(cyc);
            prev_to = (timeout_err === 1'b1);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic randomizeTables();
        for (int ch = 0; ch < 8; ch++) begin
            lat_tab[ch]  = int'($urandom_range(1, 30));
            data_tab[ch] = 12'($urandom);
            dead[ch]     = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_CHANNELS-1:0] m);
        @(negedge clk);
        b_start        = log_start_ch.size();
        b_res          = log_res_ch.size();
        b_fd           = log_fd_cyc.size();
        b_to           = log_to_cyc.size();
        channel_enable = m;
        sample_trigger = 1'b1;
        trig_cyc       = cyc;
        @(negedge clk);
        sample_trigger = 1'b0;
    endtask

    // Frame timeline: channels run in ascending order; a live channel occupies
    // START + lat cycles of WAIT + NEXT, a dead one START + TIMEOUT_CYCLES + NEXT.
    task automatic modelFrame(input logic [NUM_CHANNELS-1:0] m);
        int t;
        int nxt;
        exp_start_ch.delete();
        exp_start_cyc.delete();
        exp_res_ch.delete();
        exp_res_data.delete();
        exp_res_cyc.delete();
        exp_to_cyc.delete();
        t          = trig_cyc + 1;
        exp_fd_cyc = trig_cyc + 1;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (m[ch]) begin
                exp_start_ch.push_back(ch);
                exp_start_cyc.push_back(t);
                if (dead[ch]) begin
                    nxt = t + TIMEOUT_CYCLES + 1;
                    exp_to_cyc.push_back(nxt);
                end else begin
                    nxt = t + lat_tab[ch] + 1;
                    exp_res_ch.push_back(ch);
                    exp_res_data.push_back(data_tab[ch]);
                    exp_res_cyc.push_back(nxt);
                end
                exp_fd_cyc = nxt;
                t          = nxt + 1;
            end
        end
    endtask

    task automatic waitFrame();
        int n;
        n = 0;
        while (log_fd_cyc.size() == b_fd && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("frame_done_count", log_fd_cyc.size() - b_fd, 1);
    endtask

    task automatic compareFrame();
        checkOutput("start_count", log_start_ch.size() - b_start, exp_start_ch.size());
        for (int i = 0; i < exp_start_ch.size() && b_start + i < log_start_ch.size(); i++) begin
            checkOutput($sformatf("start%0d_ch", i), log_start_ch[b_start + i], exp_start_ch[i]);
            checkOutput($sformatf("start%0d_cyc", i), log_start_cyc[b_start + i], exp_start_cyc[i]);
        end
        checkOutput("result_count", log_res_ch.size() - b_res, exp_res_ch.size());
        for (int i = 0; i < exp_res_ch.size() && b_res + i < log_res_ch.size(); i++) begin
            checkOutput($sformatf("result%0d_ch", i), log_res_ch[b_res + i], exp_res_ch[i]);
            checkOutput($sformatf("result%0d_data", i), 32'(log_res_data[b_res + i]),
                        32'(exp_res_data[i]));
            checkOutput($sformatf("result%0d_cyc", i), log_res_cyc[b_res + i], exp_res_cyc[i]);
        end
        if (log_fd_cyc.size() > b_fd) begin
            checkOutput("frame_done_cyc", log_fd_cyc[b_fd], exp_fd_cyc);
        end
        checkOutput("timeout_count", log_to_cyc.size() - b_to, exp_to_cyc.size());
        for (int i = 0; i < exp_to_cyc.size() && b_to + i < log_to_cyc.size(); i++) begin
            checkOutput($sformatf("timeout%0d_cyc", i), log_to_cyc[b_to + i], exp_to_cyc[i]);
        end
    endtask

    initial begin
        int res_before;
        int fd_before;
        logic [NUM_CHANNELS-1:0] m;

        checks         = 0;
        passed         = 0;
        reset          = 1'b1;
        sample_trigger = 1'b0;
        clear_flags    = 1'b0;
        channel_enable = '0;
        spur_done      = 1'b0;
        spur_data      = '0;
        for (int ch = 0; ch < 8; ch++) begin
            lat_tab[ch]  = 1;
            data_tab[ch] = '0;
            dead[ch]     = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 32'({adc_start, adc_channel, result_valid, result_channel,
                    result_data, frame_done, busy, overrun, timeout_err}), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] all channels, fixed latency 20");
        for (int ch = 0; ch < 8; ch++) begin
            lat_tab[ch]  = 20;
            data_tab[ch] = 12'(12'h100 + ch);
        end
        applyStimulus(4'b1111);
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
        modelFrame(4'b1111);
        waitFrame();
        compareFrame();
        checkOutput("busy_after_frame", 32'(busy), 32'd0);

        $display("[TB] adc_done while idle is ignored");
        res_before = log_res_ch.size();
        @(negedge clk);
        spur_done = 1'b1;
        spur_data = 12'h5A5;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_done_no_result", log_res_ch.size() - res_before, 0);
        checkOutput("result_data_held", 32'(result_data), 32'(exp_res_data[exp_res_data.size() - 1]));
        checkOutput("result_channel_held", 32'(result_channel), 32'(exp_res_ch[exp_res_ch.size() - 1]));

        $display("[TB] sparse and empty masks");
        randomizeTables();
        applyStimulus(4'b1010);
        modelFrame(4'b1010);
        waitFrame();
        compareFrame();
        applyStimulus(4'b0000);
        modelFrame(4'b0000);
        waitFrame();
        compareFrame();

        $display("[TB] random masks");
        for (int f = 0; f < 4; f++) begin
            randomizeTables();
            m = NUM_CHANNELS'($urandom_range(1, (1 << NUM_CHANNELS) - 1));
            applyStimulus(m);
            modelFrame(m);
            waitFrame();
            compareFrame();
        end

        $display("[TB] ch2 never answers");
        randomizeTables();
        dead[2] = 1'b1;
        applyStimulus(4'b1111);
        modelFrame(4'b1111);
        waitFrame();
        compareFrame();
        checkOutput("timeout_sticky", 32'(timeout_err), 32'd1);
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        checkOutput("timeout_cleared", 32'(timeout_err), 32'd0);
        dead[2] = 1'b0;

        $display("[TB] trigger and enable change mid-scan");
        randomizeTables();
        applyStimulus(4'b1111);
        modelFrame(4'b1111);
        repeat (3) @(negedge clk);
        sample_trigger = 1'b1;
        channel_enable = 4'b0001;
        @(negedge clk);
        sample_trigger = 1'b0;
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        waitFrame();
        compareFrame();
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        randomizeTables();
        applyStimulus(4'b1111);
        modelFrame(4'b1111);
        repeat (3) @(negedge clk);
        sample_trigger = 1'b1;
        clear_flags    = 1'b1;
        @(negedge clk);
        sample_trigger = 1'b0;
        clear_flags    = 1'b0;
        checkOutput("overrun_set_beats_clear", 32'(overrun), 32'd1);
        waitFrame();
        compareFrame();
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        checkOutput("overrun_cleared", 32'(overrun), 32'd0);

        $display("[TB] reset during WAIT");
        randomizeTables();
        lat_tab[0] = 25;
        applyStimulus(4'b1111);
        repeat (3) @(negedge clk);
        sample_trigger = 1'b1;
        @(negedge clk);
        sample_trigger = 1'b0;
        reset          = 1'b1;
        res_before     = log_res_ch.size();
        fd_before      = log_fd_cyc.size();
        @(negedge clk);
        checkOutput("midscan_reset_outputs", 32'({adc_start, adc_channel, result_valid,
                    result_channel, result_data, frame_done, busy, overrun, timeout_err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("no_partial_result", log_res_ch.size() - res_before, 0);
        checkOutput("no_partial_frame_done", log_fd_cyc.size() - fd_before, 0);
        randomizeTables();
        applyStimulus(4'b1111);
        modelFrame(4'b1111);
        waitFrame();
        compareFrame();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
